// File: rtl/multi_channel_timer.sv
// CHANNELS independent divide-by-(T+1) timers: registered tick strobe, 50% clk_out, one-shot done flag.
// Optional macro MCT_PRESCALE_EN gates channel advance with a shared free-running PRESCALE strobe.
module multi_channel_timer #(
   parameter int CHANNELS      = 4,
   parameter int WIDTH         = 25,
   parameter int DEFAULT_COUNT = 24999999,
   parameter int PRESCALE      = 1000
) (
   input  logic                                              clk_50_mhz,
   input  logic                                              rst_n,
   input  logic [CHANNELS-1:0]                               enable,
   input  logic [CHANNELS-1:0]                               mode,
   input  logic                                              load,
   input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] load_ch,
   input  logic [WIDTH-1:0]                                  load_val,
   output logic [CHANNELS-1:0]                               clk_out,
   output logic [CHANNELS-1:0]                               tick,
   output logic [CHANNELS-1:0]                               done
);

   localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t              state_q [CHANNELS];
   state_t              state_d [CHANNELS];
   logic [WIDTH-1:0]    count_q [CHANNELS];
   logic [WIDTH-1:0]    count_d [CHANNELS];
   logic [WIDTH-1:0]    term_q  [CHANNELS];
   logic [CHANNELS-1:0] clk_q;
   logic [CHANNELS-1:0] clk_d;
   logic [CHANNELS-1:0] tick_q;
   logic [CHANNELS-1:0] tick_d;
   logic [CHANNELS-1:0] done_q;
   logic [CHANNELS-1:0] done_d;
   logic                advance;

`ifdef MCT_PRESCALE_EN
   localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   logic [PRE_W-1:0] pre_cnt;

   always_ff @(posedge clk_50_mhz or negedge rst_n) begin
      if (!rst_n) begin
         pre_cnt <= '0;
      end else if (advance) begin
         pre_cnt <= '0;
      end else begin
         pre_cnt <= pre_cnt + PRE_W'(1);
      end
   end

   assign advance = (pre_cnt == PRE_W'(PRESCALE - 1));
`else
   // PRESCALE is required to be >= 1, so channels advance on every cycle here.
   assign advance = (PRESCALE >= 1);
`endif

   // Out-of-range load_ch values match no channel and are dropped.
   always_ff @(posedge clk_50_mhz or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < CHANNELS; i++) begin
            term_q[i] <= WIDTH'(DEFAULT_COUNT);
         end
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            if (load && (load_ch == CH_W'(i))) begin
               term_q[i] <= load_val;
            end
         end
      end
   end

   always_ff @(posedge clk_50_mhz or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < CHANNELS; i++) begin
            state_q[i] <= ST_IDLE;
            count_q[i] <= '0;
         end
         clk_q  <= '0;
         tick_q <= '0;
         done_q <= '0;
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            state_q[i] <= state_d[i];
            count_q[i] <= count_d[i];
         end
         clk_q  <= clk_d;
         tick_q <= tick_d;
         done_q <= done_d;
      end
   end

   always_comb begin
      for (int i = 0; i < CHANNELS; i++) begin
         state_d[i] = state_q[i];
         count_d[i] = count_q[i];
         clk_d[i]   = clk_q[i];
         tick_d[i]  = 1'b0;
         done_d[i]  = done_q[i];
         case (state_q[i])
            ST_IDLE: begin
               count_d[i] = '0;
               clk_d[i]   = 1'b0;
               done_d[i]  = 1'b0;
               if (enable[i]) begin
                  state_d[i] = ST_RUN;
               end
            end
            ST_RUN: begin
               done_d[i] = 1'b0;
               // Dropping enable wins over a terminal-count hit on the same edge.
               if (!enable[i]) begin
                  state_d[i] = ST_IDLE;
                  count_d[i] = '0;
                  clk_d[i]   = 1'b0;
               end else if (advance) begin
                  if (count_q[i] >= term_q[i]) begin
                     count_d[i] = '0;
                     tick_d[i]  = 1'b1;
                     clk_d[i]   = ~clk_q[i];
                     if (mode[i]) begin
                        state_d[i] = ST_DONE;
                        done_d[i]  = 1'b1;
                     end
                  end else begin
                     count_d[i] = count_q[i] + WIDTH'(1);
                  end
               end
            end
            ST_DONE: begin
               count_d[i] = '0;
               done_d[i]  = 1'b1;
               if (!enable[i]) begin
                  state_d[i] = ST_IDLE;
                  done_d[i]  = 1'b0;
                  clk_d[i]   = 1'b0;
               end
            end
            default: begin
               state_d[i] = ST_IDLE;
               count_d[i] = '0;
               clk_d[i]   = 1'b0;
               done_d[i]  = 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      clk_out = clk_q;
      tick    = tick_q;
      done    = done_q;
   end

endmodule

// File: tb/tb_multi_channel_timer.sv
// Self-checking bench for multi_channel_timer: directed scenarios plus random traffic against a cycle-time model.
module tb_multi_channel_timer;

   localparam int CH  = 5;
   localparam int W   = 12;
   localparam int DEF = 20;
`ifdef MCT_PRESCALE_EN
   localparam int P = 4;
`else
   localparam int P = 1;
`endif

   logic          clk_50_mhz = 1'b0;
   logic          rst_n      = 1'b0;
   logic [CH-1:0] enable     = '0;
   logic [CH-1:0] mode       = '0;
   logic          load       = 1'b0;
   logic [2:0]    load_ch    = '0;
   logic [W-1:0]  load_val   = '0;
   logic [CH-1:0] clk_out;
   logic [CH-1:0] tick;
   logic [CH-1:0] done;

   always #10 clk_50_mhz = ~clk_50_mhz;

   multi_channel_timer #(
      .CHANNELS      (CH),
      .WIDTH         (W),
      .DEFAULT_COUNT (DEF),
      .PRESCALE      (P)
   ) dut (
      .clk_50_mhz (clk_50_mhz),
      .rst_n      (rst_n),
      .enable     (enable),
      .mode       (mode),
      .load       (load),
      .load_ch    (load_ch),
      .load_val   (load_val),
      .clk_out    (clk_out),
      .tick       (tick),
      .done       (done)
   );

   int total = 0;
   int bad   = 0;

   // Model: a channel hits once T+1 advance strobes have elapsed since entry or its last hit.
   int            m_term   [CH];
   bit            m_run    [CH];
   bit            m_fin    [CH];
   longint        m_anchor [CH];
   longint        edges;
   longint        strobes;
   logic [CH-1:0] e_clk;
   logic [CH-1:0] e_tick;
   logic [CH-1:0] e_done;

   task automatic model_reset();
      for (int i = 0; i < CH; i++) begin
         m_term[i]   = DEF;
         m_run[i]    = 1'b0;
         m_fin[i]    = 1'b0;
         m_anchor[i] = 0;
      end
      edges   = 0;
      strobes = 0;
      e_clk   = '0;
      e_tick  = '0;
      e_done  = '0;
   endtask

   task automatic model_edge();
      bit strobe;
      edges++;
      strobe = (edges % P) == 0;
      if (strobe) strobes++;
      e_tick = '0;
      for (int i = 0; i < CH; i++) begin
         if (m_fin[i]) begin
            if (!enable[i]) begin
               m_fin[i]  = 1'b0;
               e_done[i] = 1'b0;
               e_clk[i]  = 1'b0;
            end
         end else if (!m_run[i]) begin
            e_clk[i]  = 1'b0;
            e_done[i] = 1'b0;
            if (enable[i]) begin
               m_run[i]    = 1'b1;
               m_anchor[i] = strobes;
            end
         end else if (!enable[i]) begin
            m_run[i] = 1'b0;
            e_clk[i] = 1'b0;
         end else if (strobe && (strobes - m_anchor[i] >= longint'(m_term[i]) + 1)) begin
            e_tick[i]   = 1'b1;
            e_clk[i]    = ~e_clk[i];
            m_anchor[i] = strobes;
            if (mode[i]) begin
               m_run[i]  = 1'b0;
               m_fin[i]  = 1'b1;
               e_done[i] = 1'b1;
            end
         end
      end
      if (load && (int'(load_ch) < CH)) m_term[load_ch] = int'(load_val);
   endtask

   task automatic step();
      @(posedge clk_50_mhz);
      model_edge();
      #1;
   endtask

   task automatic test_reset();
      rst_n  = 1'b0;
      enable = '0;
      mode   = '0;
      load   = 1'b0;
      repeat (3) @(posedge clk_50_mhz);
      #1;
      total++;
      if ({clk_out, tick, done} !== '0) begin
         bad++;
         $display("FAIL reset_state got=%h want=0", {clk_out, tick, done});
      end
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic test_periodic();
      load = 1'b1; load_ch = 3'd0; load_val = W'(3);
      step();
      load = 1'b0;
      enable[0] = 1'b1;
      for (int k = 0; k < 40; k++) begin
         step();
         total++;
         if ({clk_out, tick, done} !== {e_clk, e_tick, e_done}) begin
            bad++;
            $display("FAIL periodic cyc=%0d clk/tick/done got=%h/%h/%h want=%h/%h/%h",
                     k, clk_out, tick, done, e_clk, e_tick, e_done);
         end
      end
      enable[0] = 1'b0;
      step();
      total++;
      if ({clk_out[0], tick[0]} !== 2'b00) begin
         bad++;
         $display("FAIL periodic_stop got=%b want=00", {clk_out[0], tick[0]});
      end
   endtask

   task automatic test_zero_term();
      load = 1'b1; load_ch = 3'd1; load_val = '0;
      step();
      load = 1'b0;
      enable[1] = 1'b1;
      for (int k = 0; k < 20; k++) begin
         step();
         total++;
         if ({clk_out, tick, done} !== {e_clk, e_tick, e_done}) begin
            bad++;
            $display("FAIL zero_term cyc=%0d clk/tick/done got=%h/%h/%h want=%h/%h/%h",
                     k, clk_out, tick, done, e_clk, e_tick, e_done);
         end
      end
      enable[1] = 1'b0;
      step();
      total++;
      if ({clk_out[1], tick[1]} !== 2'b00) begin
         bad++;
         $display("FAIL zero_term_stop got=%b want=00", {clk_out[1], tick[1]});
      end
   endtask

   task automatic test_one_shot();
      int n_ticks = 0;
      load = 1'b1; load_ch = 3'd2; load_val = W'(5);
      mode[2] = 1'b1;
      step();
      load = 1'b0;
      enable[2] = 1'b1;
      for (int k = 0; k < 40; k++) begin
         step();
         if (tick[2]) n_ticks++;
         total++;
         if ({clk_out, tick, done} !== {e_clk, e_tick, e_done}) begin
            bad++;
            $display("FAIL one_shot cyc=%0d clk/tick/done got=%h/%h/%h want=%h/%h/%h",
                     k, clk_out, tick, done, e_clk, e_tick, e_done);
         end
      end
      total++;
      if (n_ticks !== 1) begin
         bad++;
         $display("FAIL one_shot_ticks got=%0d want=1", n_ticks);
      end
      total++;
      if ({done[2], clk_out[2]} !== 2'b11) begin
         bad++;
         $display("FAIL one_shot_hold done/clk got=%b want=11", {done[2], clk_out[2]});
      end
      enable[2] = 1'b0;
      step();
      mode[2] = 1'b0;
      total++;
      if ({done[2], clk_out[2]} !== 2'b00) begin
         bad++;
         $display("FAIL one_shot_clear done/clk got=%b want=00", {done[2], clk_out[2]});
      end
   endtask

   task automatic test_load_midrun();
      load = 1'b1; load_ch = 3'd3; load_val = W'(10);
      step();
      load = 1'b0;
      enable[3] = 1'b1;
      enable[0] = 1'b1;
      step();
      for (int k = 0; k < 7 * P + 30; k++) begin
         load = 1'b0;
         if (k == 7 * P) begin
            load = 1'b1; load_ch = 3'd3; load_val = W'(4);
         end else if (k == 7 * P + 3) begin
            load = 1'b1; load_ch = 3'd5; load_val = W'(1);
         end else if (k == 7 * P + 9) begin
            load = 1'b1; load_ch = 3'd7; load_val = W'(0);
         end
         step();
         total++;
         if ({clk_out, tick, done} !== {e_clk, e_tick, e_done}) begin
            bad++;
            $display("FAIL load_midrun cyc=%0d clk/tick/done got=%h/%h/%h want=%h/%h/%h",
                     k, clk_out, tick, done, e_clk, e_tick, e_done);
         end
      end
      load = 1'b0;
      enable[3] = 1'b0;
      step();
   endtask

   task automatic test_reset_midrun();
      int first_edge = -1;
      int exp_edge;
      for (int k = 0; k < 10; k++) begin
         step();
         total++;
         if ({clk_out, tick, done} !== {e_clk, e_tick, e_done}) begin
            bad++;
            $display("FAIL pre_reset cyc=%0d clk/tick/done got=%h/%h/%h want=%h/%h/%h",
                     k, clk_out, tick, done, e_clk, e_tick, e_done);
         end
      end
      #5 rst_n = 1'b0;
      #1;
      total++;
      if ({clk_out, tick, done} !== '0) begin
         bad++;
         $display("FAIL async_reset got=%h want=0", {clk_out, tick, done});
      end
      @(posedge clk_50_mhz);
      #1 rst_n = 1'b1;
      model_reset();
      exp_edge = (P == 1) ? DEF + 2 : (DEF + 1) * P;
      for (int k = 1; k <= (DEF + 2) * P + 10; k++) begin
         step();
         if (tick[0] && first_edge < 0) first_edge = k;
         total++;
         if ({clk_out, tick, done} !== {e_clk, e_tick, e_done}) begin
            bad++;
            $display("FAIL post_reset cyc=%0d clk/tick/done got=%h/%h/%h want=%h/%h/%h",
                     k, clk_out, tick, done, e_clk, e_tick, e_done);
         end
      end
      total++;
      if (first_edge != exp_edge) begin
         bad++;
         $display("FAIL default_count_tick edge got=%0d want=%0d", first_edge, exp_edge);
      end
      enable = '0;
      step();
   endtask

   task automatic test_random();
      for (int k = 0; k < 400; k++) begin
         load = 1'b0;
         for (int i = 0; i < CH; i++) begin
            if ($urandom_range(0, 15) == 0) enable[i] = ~enable[i];
            if ($urandom_range(0, 31) == 0) mode[i] = ~mode[i];
         end
         if ($urandom_range(0, 7) == 0) begin
            load     = 1'b1;
            load_ch  = 3'($urandom_range(0, 7));
            load_val = W'($urandom_range(0, 7));
         end
         step();
         total++;
         if ({clk_out, tick, done} !== {e_clk, e_tick, e_done}) begin
            bad++;
            $display("FAIL random cyc=%0d clk/tick/done got=%h/%h/%h want=%h/%h/%h",
                     k, clk_out, tick, done, e_clk, e_tick, e_done);
         end
      end
      load   = 1'b0;
      enable = '0;
      mode   = '0;
      step();
   endtask

`ifdef MCT_PRESCALE_EN
   task automatic test_prescale();
      int last = -1;
      load = 1'b1; load_ch = 3'd4; load_val = W'(1);
      step();
      load = 1'b0;
      enable[4] = 1'b1;
      for (int k = 0; k < 60; k++) begin
         step();
         if (tick[4]) begin
            if (last >= 0) begin
               total++;
               if (k - last != 2 * P) begin
                  bad++;
                  $display("FAIL prescale_period got=%0d want=%0d", k - last, 2 * P);
               end
            end
            last = k;
         end
         total++;
         if ({clk_out, tick, done} !== {e_clk, e_tick, e_done}) begin
            bad++;
            $display("FAIL prescale cyc=%0d clk/tick/done got=%h/%h/%h want=%h/%h/%h",
                     k, clk_out, tick, done, e_clk, e_tick, e_done);
         end
      end
      enable[4] = 1'b0;
      step();
   endtask
`endif

   initial begin
      #2ms;
      $display("FAIL timeout simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_periodic();
      test_zero_term();
      test_one_shot();
      test_load_midrun();
      test_reset_midrun();
      test_random();
`ifdef MCT_PRESCALE_EN
      test_prescale();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
